rgb565_to_hsv: RTL and testbench

- Streaming pixel converter that sits directly upstream of the colour binning stage.
- Takes camera RGB565 pixels with a valid strobe and produces fixed-point hue, saturation and value with a matching valid strobe.
- Fully pipelined: one pixel per clock, fixed latency, no backpressure. The binning stage counts every o_valid as one pixel.
- Output format is Q9.7. Hue is in degrees 0..359, sat and value in percent 0..100. Bits [15:7] carry the integer part.

---
 rtl/rgb565_to_hsv.sv | 196 +++++++++++++++++++
 tb/tb_rgb565_to_hsv.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rgb565_to_hsv.sv
// Streaming RGB565 -> HSV converter, Q9.7 outputs, one pixel per clock.
// Two unrolled restoring dividers (hue and saturation) run in lockstep, one quotient bit per stage.
module rgb565_to_hsv #(
  parameter int unsigned QBITS = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic [15:0] o_hue,
  output logic [15:0] o_sat,
  output logic [15:0] o_value,
  output logic        o_valid
);

  localparam int unsigned W = QBITS + 8;

  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_e;

  // Stage 1: expanded channels
  logic [7:0] r8_d, r8_q, g8_d, g8_q, b8_d, b8_q;
  logic       v1_d, v1_q;

  // Stage 2: max/min/delta/sector
  logic [7:0]        max_d, max_q, delta_d, delta_q, min_c;
  logic signed [8:0] diff_d, diff_q;
  sector_e           sec2_d, sec2_q;
  logic              v2_d, v2_q;

  // Index 0 holds the divider operands, index j the state after quotient bit QBITS-j
  logic [7:0]       absd_c;
  logic [W-1:0]     hrem_d [QBITS+1];
  logic [W-1:0]     hrem_q [QBITS+1];
  logic [W-1:0]     srem_d [QBITS+1];
  logic [W-1:0]     srem_q [QBITS+1];
  logic [QBITS-1:0] hquo_d [QBITS+1];
  logic [QBITS-1:0] hquo_q [QBITS+1];
  logic [QBITS-1:0] squo_d [QBITS+1];
  logic [QBITS-1:0] squo_q [QBITS+1];
  logic [7:0]       hden_d [QBITS+1];
  logic [7:0]       hden_q [QBITS+1];
  logic [7:0]       sden_d [QBITS+1];
  logic [7:0]       sden_q [QBITS+1];
  logic [15:0]      val_d  [QBITS+1];
  logic [15:0]      val_q  [QBITS+1];
  sector_e          sec_d  [QBITS+1];
  sector_e          sec_q  [QBITS+1];
  logic [QBITS:0]   neg_d, neg_q, dz_d, dz_q, mz_d, mz_q, vd_d, vd_q;

  // Output stage
  logic [15:0] hue_d, hue_q, sat_d, sat_q, value_d, value_q;
  logic        out_valid_d, out_valid_q;
  logic [15:0] hq_c, sq_c, base_c;

  always_comb begin
    r8_d = {i_data[15:11], i_data[15:13]};
    g8_d = {i_data[10:5],  i_data[10:9]};
    b8_d = {i_data[4:0],   i_data[4:2]};
    v1_d = i_valid;
  end

  always_comb begin
    v2_d = v1_q;
    if (r8_q >= g8_q && r8_q >= b8_q) begin
      max_d  = r8_q;
      diff_d = $signed({1'b0, g8_q}) - $signed({1'b0, b8_q});
      sec2_d = SEC_R;
    end else if (g8_q >= b8_q) begin
      max_d  = g8_q;
      diff_d = $signed({1'b0, b8_q}) - $signed({1'b0, r8_q});
      sec2_d = SEC_G;
    end else begin
      max_d  = b8_q;
      diff_d = $signed({1'b0, r8_q}) - $signed({1'b0, g8_q});
      sec2_d = SEC_B;
    end
    if (r8_q <= g8_q && r8_q <= b8_q) min_c = r8_q;
    else if (g8_q <= b8_q)            min_c = g8_q;
    else                              min_c = b8_q;
    delta_d = max_d - min_c;
  end

  always_comb begin
    absd_c    = diff_q[8] ? 8'(-diff_q) : diff_q[7:0];
    hrem_d[0] = W'(absd_c) * W'(7680);
    srem_d[0] = W'(delta_q) * W'(12800);
    hquo_d[0] = '0;
    squo_d[0] = '0;
    hden_d[0] = delta_q;
    sden_d[0] = max_q;
    val_d[0]  = 16'((22'(max_q) * 22'(12851)) >> 8);
    sec_d[0]  = sec2_q;
    neg_d[0]  = diff_q[8];
    dz_d[0]   = (delta_q == '0);
    mz_d[0]   = (max_q == '0);
    vd_d[0]   = v2_q;
    for (int unsigned j = 1; j <= QBITS; j++) begin
      hden_d[j] = hden_q[j-1];
      sden_d[j] = sden_q[j-1];
      val_d[j]  = val_q[j-1];
      sec_d[j]  = sec_q[j-1];
      neg_d[j]  = neg_q[j-1];
      dz_d[j]   = dz_q[j-1];
      mz_d[j]   = mz_q[j-1];
      vd_d[j]   = vd_q[j-1];
      if (hrem_q[j-1] >= (W'(hden_q[j-1]) << (QBITS - j))) begin
        hrem_d[j] = hrem_q[j-1] - (W'(hden_q[j-1]) << (QBITS - j));
        hquo_d[j] = hquo_q[j-1] | (QBITS'(1) << (QBITS - j));
      end else begin
        hrem_d[j] = hrem_q[j-1];
        hquo_d[j] = hquo_q[j-1];
      end
      if (srem_q[j-1] >= (W'(sden_q[j-1]) << (QBITS - j))) begin
        srem_d[j] = srem_q[j-1] - (W'(sden_q[j-1]) << (QBITS - j));
        squo_d[j] = squo_q[j-1] | (QBITS'(1) << (QBITS - j));
      end else begin
        srem_d[j] = srem_q[j-1];
        squo_d[j] = squo_q[j-1];
      end
    end
  end

  always_comb begin
    out_valid_d = vd_q[QBITS];
    hue_d       = hue_q;
    sat_d       = sat_q;
    value_d     = value_q;
    hq_c        = 16'(hquo_q[QBITS]);
    sq_c        = 16'(squo_q[QBITS]);
    case (sec_q[QBITS])
      SEC_G:   base_c = 16'd15360;
      SEC_B:   base_c = 16'd30720;
      default: base_c = 16'd0;
    endcase
    if (vd_q[QBITS]) begin
      value_d = val_q[QBITS];
      if (dz_q[QBITS]) begin
        hue_d = '0;
        sat_d = '0;
      end else begin
        // A negative result can only come from the red sector; wrap it into 300..359 deg
        if (!neg_q[QBITS])       hue_d = base_c + hq_c;
        else if (base_c >= hq_c) hue_d = base_c - hq_c;
        else                     hue_d = base_c + 16'd46080 - hq_c;
        sat_d = mz_q[QBITS] ? '0 : sq_c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      vd_q        <= '0;
      out_valid_q <= 1'b0;
      hue_q       <= '0;
      sat_q       <= '0;
      value_q     <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      vd_q        <= vd_d;
      out_valid_q <= out_valid_d;
      hue_q       <= hue_d;
      sat_q       <= sat_d;
      value_q     <= value_d;
    end
  end

  always_ff @(posedge i_clk) begin
    r8_q    <= r8_d;
    g8_q    <= g8_d;
    b8_q    <= b8_d;
    max_q   <= max_d;
    delta_q <= delta_d;
    diff_q  <= diff_d;
    sec2_q  <= sec2_d;
    hrem_q  <= hrem_d;
    srem_q  <= srem_d;
    hquo_q  <= hquo_d;
    squo_q  <= squo_d;
    hden_q  <= hden_d;
    sden_q  <= sden_d;
    val_q   <= val_d;
    sec_q   <= sec_d;
    neg_q   <= neg_d;
    dz_q    <= dz_d;
    mz_q    <= mz_d;
  end

  assign o_hue   = hue_q;
  assign o_sat   = sat_q;
  assign o_value = value_q;
  assign o_valid = out_valid_q;

endmodule

// File: tb/tb_rgb565_to_hsv.sv
// Directed and random-stream bench for rgb565_to_hsv with hand-computed vectors
// and an integer reference model for the stream.
module tb_rgb565_to_hsv;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] data;
  logic [15:0] hue, sat, value;
  logic        ovalid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  rgb565_to_hsv #(.QBITS(14)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_hue   (hue),
    .o_sat   (sat),
    .o_value (value),
    .o_valid (ovalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] px, output logic [15:0] h,
                                output logic [15:0] s, output logic [15:0] v);
    int r, g, b, mx, mn, dl, df, base, q, hh;
    r = int'({px[15:11], px[15:13]});
    g = int'({px[10:5], px[10:9]});
    b = int'({px[4:0], px[4:2]});
    if (r >= g && r >= b) begin mx = r; df = g - b; base = 0;     end
    else if (g >= b)      begin mx = g; df = b - r; base = 15360; end
    else                  begin mx = b; df = r - g; base = 30720; end
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    dl = mx - mn;
    v = 16'((mx * 12851) / 256);
    if (dl == 0) begin
      h = 16'd0;
      s = 16'd0;
    end else begin
      q  = ((df < 0) ? -df : df) * 7680 / dl;
      hh = (df < 0) ? base - q : base + q;
      if (hh < 0) hh += 46080;
      h = 16'(hh);
      s = 16'(dl * 12800 / mx);
    end
  endfunction

  // Entered and left at a negedge; the pulse is sampled on the following posedge.
  task automatic pulse(input string tag, input logic [15:0] px,
                       input logic [15:0] eh, input logic [15:0] es, input logic [15:0] ev);
    int unsigned lat;
    data  = px;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    data  = 16'($urandom);
    lat   = 1;
    while (ovalid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 18);
    check({tag, " hue"}, hue, eh);
    check({tag, " sat"}, sat, es);
    check({tag, " value"}, value, ev);
    @(negedge clk);
    check({tag, " single"}, ovalid, 0);
    check({tag, " hold_hue"}, hue, eh);
    check({tag, " hold_val"}, value, ev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] px, eh, es, ev;
    logic [15:0] qh[$], qs[$], qv[$];
    int unsigned got;

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset valid", ovalid, 0);
    check("reset hue", hue, 0);
    check("reset sat", sat, 0);
    check("reset value", value, 0);
    rst = 1'b0;

    pulse("red",     16'hF800, 16'd0,     16'd12800, 16'd12800);
    pulse("green",   16'h07E0, 16'd15360, 16'd12800, 16'd12800);
    pulse("blue",    16'h001F, 16'd30720, 16'd12800, 16'd12800);
    pulse("yellow",  16'hFFE0, 16'd7680,  16'd12800, 16'd12800);
    pulse("cyan",    16'h07FF, 16'd23040, 16'd12800, 16'd12800);
    pulse("white",   16'hFFFF, 16'd0,     16'd0,     16'd12800);
    pulse("black",   16'h0000, 16'd0,     16'd0,     16'd0);
    // G6=32 expands to 130 while R/B expand to 132: R wins the tie, diff=-2, delta=2
    pulse("mid8410", 16'h8410, 16'd38400, 16'd193,   16'd6626);
    pulse("magenta", 16'hF81F, 16'd38400, 16'd12800, 16'd12800);
    pulse("orange",  16'hFC00, 16'd3915,  16'd12800, 16'd12800);
    pulse("azure",   16'h041F, 16'd26805, 16'd12800, 16'd12800);

    for (int i = 0; i < 20; i++) begin
      data  = 16'($urandom);
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("midrst valid", ovalid, 0);
    check("midrst hue", hue, 0);
    check("midrst sat", sat, 0);
    check("midrst value", value, 0);
    rst = 1'b0;
    pulse("post_rst", 16'h001F, 16'd30720, 16'd12800, 16'd12800);

    got = 0;
    for (int c = 0; c < 760; c++) begin
      if (ovalid === 1'b1) begin
        got++;
        if (qh.size() > 0) begin
          eh = qh.pop_front();
          es = qs.pop_front();
          ev = qv.pop_front();
          check("stream hue", hue, eh);
          check("stream sat", sat, es);
          check("stream value", value, ev);
        end
      end
      if (c < 720 && (c % 3) != 2) begin
        px = 16'($urandom);
        model(px, eh, es, ev);
        qh.push_back(eh);
        qs.push_back(es);
        qv.push_back(ev);
        data  = px;
        valid = 1'b1;
      end else begin
        data  = 16'($urandom);
        valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream count", got, 480);
    check("stream leftover", qh.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
